// File: rtl/sm_clk_ctrl_pkg.sv
// Shared definitions for the schoolMIPS clock controller: FSM state
// encodings and the divider tap clamp helper.
package sm_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    SM_CC_HALT = 2'd0,
    SM_CC_RUN  = 2'd1,
    SM_CC_STEP = 2'd2
  } sm_cc_state_t;

  // Tap index = shift + div, computed at full width and clamped to the
  // counter MSB so an oversized divider select never indexes out of range.
  function automatic int unsigned sm_cc_clamp_idx(
    input int unsigned shift,
    input int unsigned div,
    input int unsigned cntr_w
  );
    int unsigned sum;
    sum = shift + div;
    if (sum > cntr_w - 1) begin
      return cntr_w - 1;
    end
    return sum;
  endfunction

endpackage

// File: rtl/sm_sync.sv
// Multi-flop synchroniser with synchronous active-high reset. One instance
// per asynchronous input group; the output is the last stage of the chain.
module sm_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [STAGES];

  // Shift the asynchronous input through STAGES flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/sm_clk_ctrl.sv
// Clock generator for the schoolMIPS core: power-of-two divider with
// run / halt / single-step control and a one-cycle tick enable.
// Optional feature: define SM_CLK_CTRL_CYCLES_EN to add the 32-bit tick
// counter and its cycles port.
// The FSM state is exposed on state_dbg for checkers.
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter int CNTR_W      = 32,
  parameter int SHIFT       = 16,
  parameter int DIV_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic [DIV_W-1:0] devide,
  input  logic             enable,
  input  logic             step,
  output logic             clkOut,
  output logic             tick,
  output logic             halted,
  output logic [1:0]       state_dbg
`ifdef SM_CLK_CTRL_CYCLES_EN
  ,
  output logic [31:0]      cycles
`endif
);

  localparam int IDX_W = (CNTR_W > 1) ? $clog2(CNTR_W) : 1;

  logic [DIV_W-1:0]  devide_s;
  logic [DIV_W-1:0]  devide_s_d;
  logic              enable_s;
  logic              step_s;
  logic              step_s_d;
  logic              step_rise;
  logic              div_chg;
  logic [IDX_W-1:0]  idx;
  logic [CNTR_W-1:0] cntr;
  logic [CNTR_W-1:0] cntr_next;
  logic              clk_out_next;
  logic              tick_next;
  sm_cc_state_t      state;
  sm_cc_state_t      state_next;

  sm_sync #(.WIDTH(DIV_W), .STAGES(SYNC_STAGES)) u_sync_div (
    .clk (clkIn),
    .rst (rst),
    .d   (devide),
    .q   (devide_s)
  );

  sm_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_en (
    .clk (clkIn),
    .rst (rst),
    .d   (enable),
    .q   (enable_s)
  );

  sm_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_step (
    .clk (clkIn),
    .rst (rst),
    .d   (step),
    .q   (step_s)
  );

  assign step_rise = step_s & ~step_s_d;
  assign div_chg   = (devide_s != devide_s_d);
  assign idx       = IDX_W'(sm_cc_clamp_idx(SHIFT, {{(32-DIV_W){1'b0}}, devide_s}, CNTR_W));
  assign state_dbg = state;

  // Next counter, divided clock, tick and FSM state. A tick is withheld in the
  // cycle after a tap change because the level jump is not a real clock edge.
  always_comb begin
    cntr_next    = cntr;
    clk_out_next = clkOut;
    tick_next    = 1'b0;
    state_next   = state;
    if (state != SM_CC_HALT) begin
      cntr_next    = cntr + CNTR_W'(1);
      clk_out_next = cntr_next[idx];
    end
    tick_next = clk_out_next & ~clkOut & ~div_chg;
    case (state)
      SM_CC_HALT: begin
        if (enable_s) begin
          state_next = SM_CC_RUN;
        end else if (step_rise) begin
          state_next = SM_CC_STEP;
        end
      end
      SM_CC_RUN: begin
        if (!enable_s) begin
          state_next = SM_CC_HALT;
        end
      end
      SM_CC_STEP: begin
        if (enable_s) begin
          state_next = SM_CC_RUN;
        end else if (tick_next) begin
          state_next = SM_CC_HALT;
        end
      end
      default: state_next = SM_CC_HALT;
    endcase
  end

  // Register counter, outputs, FSM and the edge/change detectors.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      state      <= SM_CC_HALT;
      cntr       <= '0;
      clkOut     <= 1'b0;
      tick       <= 1'b0;
      halted     <= 1'b1;
      devide_s_d <= '0;
      step_s_d   <= 1'b0;
    end else begin
      state      <= state_next;
      cntr       <= cntr_next;
      clkOut     <= clk_out_next;
      tick       <= tick_next;
      halted     <= (state_next == SM_CC_HALT);
      devide_s_d <= devide_s;
      step_s_d   <= step_s;
    end
  end

`ifdef SM_CLK_CTRL_CYCLES_EN
  // Count ticks; updates on the same edge that raises tick.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      cycles <= '0;
    end else if (tick_next) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Directed bench for sm_clk_ctrl (CNTR_W=8, SHIFT=2, DIV_W=2) plus a second
// instance (SHIFT=6, DIV_W=4) for the tap clamp.
module tb_sm_clk_ctrl;
  import sm_clk_ctrl_pkg::*;

  // clock / reset
  logic clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  logic       rst, enable, step;
  logic [1:0] devide;
  logic       clkOut, tick, halted;
  logic [1:0] state_dbg;

  logic       rst2;
  logic [3:0] devide2;
  logic       enable2, step2;
  logic       clkOut2, tick2, halted2;
  logic [1:0] state_dbg2;

`ifdef SM_CLK_CTRL_CYCLES_EN
  logic [31:0] cycles, cycles2;
`endif

  int checks     = 0;
  int errors     = 0;
  int tick_total = 0;
  int n;

  sm_clk_ctrl #(.CNTR_W(8), .SHIFT(2), .DIV_W(2), .SYNC_STAGES(2)) dut (
    .clkIn     (clkIn),
    .rst       (rst),
    .devide    (devide),
    .enable    (enable),
    .step      (step),
    .clkOut    (clkOut),
    .tick      (tick),
    .halted    (halted),
    .state_dbg (state_dbg)
`ifdef SM_CLK_CTRL_CYCLES_EN
    ,
    .cycles    (cycles)
`endif
  );

  sm_clk_ctrl #(.CNTR_W(8), .SHIFT(6), .DIV_W(4), .SYNC_STAGES(2)) dut2 (
    .clkIn     (clkIn),
    .rst       (rst2),
    .devide    (devide2),
    .enable    (enable2),
    .step      (step2),
    .clkOut    (clkOut2),
    .tick      (tick2),
    .halted    (halted2),
    .state_dbg (state_dbg2)
`ifdef SM_CLK_CTRL_CYCLES_EN
    ,
    .cycles    (cycles2)
`endif
  );

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: advance one clkIn cycle, sample 1 ns after the edge
  task automatic clk1();
    @(posedge clkIn);
    #1;
    if (tick === 1'b1) tick_total++;
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      clk1();
      cnt++;
    end while (tick !== 1'b1 && cnt < 1000);
  endtask

  task automatic wait_tick2(output int cnt);
    cnt = 0;
    do begin
      clk1();
      cnt++;
    end while (tick2 !== 1'b1 && cnt < 1000);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; devide = 2'd0; step = 1'b0;
    rst2 = 1'b1; enable2 = 1'b1; devide2 = 4'd15; step2 = 1'b0;
    repeat (3) clk1();

    // reset state
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_clkout", 32'(clkOut), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(SM_CC_HALT));

    // release: halted for 3 cycles, then RUN
    rst = 1'b0;
    clk1(); check("rel_halted_1", 32'(halted), 32'd1);
    clk1(); check("rel_halted_2", 32'(halted), 32'd1);
    clk1(); check("rel_run_halted", 32'(halted), 32'd0);
    check("rel_run_state", 32'(state_dbg), 32'(SM_CC_RUN));
    clk1(); clk1(); clk1();
    check("pre_first_tick", 32'(tick), 32'd0);
    clk1(); check("first_tick", 32'(tick), 32'd1);
    wait_tick(n); check("run_period_a", 32'(n), 32'd8);
    wait_tick(n); check("run_period_b", 32'(n), 32'd8);

    // divider 0 -> 3 while running
    devide = 2'd3;
    clk1(); clk1(); clk1();
    check("div3_no_tick", 32'(tick), 32'd0);
    wait_tick(n); check("div3_first", 32'(n), 32'd9);
    wait_tick(n); check("div3_period", 32'(n), 32'd64);

    // divider 3 -> 0 at a point where the new tap is high: no spurious tick
    repeat (33) clk1();
    devide = 2'd0;
    clk1(); clk1(); clk1();
    check("div0_suppressed", 32'(tick), 32'd0);
    wait_tick(n); check("div0_first", 32'(n), 32'd8);
    wait_tick(n); check("div0_period", 32'(n), 32'd8);

    // reset mid-RUN with cntr = 0x5A
    n = 0;
    while (dut.cntr !== 8'h5A && n < 300) begin
      clk1();
      n++;
    end
    check("reach_5a", 32'(dut.cntr), 32'h5A);
    rst = 1'b1; enable = 1'b0;
    clk1();
    check("mid_rst_cntr", 32'(dut.cntr), 32'd0);
    check("mid_rst_clkout", 32'(clkOut), 32'd0);
    check("mid_rst_tick", 32'(tick), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd1);
`ifdef SM_CLK_CTRL_CYCLES_EN
    check("mid_rst_cycles", cycles, 32'd0);
`endif
    rst = 1'b0;
    tick_total = 0;
    repeat (5) clk1();
    check("halt_frozen_cntr", 32'(dut.cntr), 32'd0);
    check("halt_stays", 32'(halted), 32'd1);

    // single step, second request while stepping is ignored
    step = 1'b1; clk1();
    step = 1'b0; clk1();
    step = 1'b1; clk1();
    check("step_state", 32'(state_dbg), 32'(SM_CC_STEP));
    check("step_halted", 32'(halted), 32'd0);
    step = 1'b0;
    repeat (30) clk1();
    check("step_one_tick", 32'(tick_total), 32'd1);
    check("step_back_halted", 32'(halted), 32'd1);
    check("step_cntr", 32'(dut.cntr), 32'd4);

    // enable raised during STEP -> RUN three cycles later
    step = 1'b1; clk1();
    step = 1'b0; enable = 1'b1; clk1();
    clk1();
    check("step2_state", 32'(state_dbg), 32'(SM_CC_STEP));
    clk1();
    check("step_to_run", 32'(state_dbg), 32'(SM_CC_RUN));
    check("step_to_run_halted", 32'(halted), 32'd0);
    wait_tick(n); check("resume_first", 32'(n), 32'd7);
    wait_tick(n); check("resume_period", 32'(n), 32'd8);

`ifdef SM_CLK_CTRL_CYCLES_EN
    n = 0;
    while (tick_total < 10 && n < 200) begin
      clk1();
      n++;
    end
    check("cycles_10", cycles, 32'd10);
`endif

    // clamp: SHIFT=6 + devide=15 -> tap 7, period 256
    rst2 = 1'b0;
    wait_tick2(n); check("clamp_first", 32'(n), 32'd131);
    wait_tick2(n); check("clamp_period", 32'(n), 32'd256);
    check("clamp_halted", 32'(halted2), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
